// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, default widths and output-buffer state encoding
//               shared by the ALU request arbiter and its ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_RES_W  = 8;

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] AND = 2'd2;
    localparam logic [1:0] OR  = 2'd3;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU; operands are zero-extended to
//               RES_W before ADD/SUB/AND/OR, SUB wraps modulo 2^RES_W.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RES_W  = DEFAULT_RES_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] w_a_ext;
    logic [RES_W-1:0] w_b_ext;

    assign w_a_ext = {{(RES_W-DATA_W){1'b0}}, a};
    assign w_b_ext = {{(RES_W-DATA_W){1'b0}}, b};

    always_comb begin
        result = '0;
        case (op)
            ADD:     result = w_a_ext + w_b_ext;
            SUB:     result = w_a_ext - w_b_ext;
            AND:     result = w_a_ext & w_b_ext;
            OR:      result = w_a_ext | w_b_ext;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Two-requester arbiter sharing one ALU, with a one-entry
//               registered response buffer and a response handshake counter.
//               ALU_ARB_RR_EN selects round-robin tie-break (else fixed prio).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RES_W  = DEFAULT_RES_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic [7:0]        ops_count
);

    buf_state_t        r_state;
    buf_state_t        w_state_next;
    logic [RES_W-1:0]  r_rsp_data;
    logic              r_rsp_id;
    logic [7:0]        r_ops_count;

    logic              w_tie_pick1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_can_accept;
    logic              w_accept;
    logic              w_drain;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [1:0]        w_alu_op;
    logic [RES_W-1:0]  w_alu_result;

`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    // A tie goes to the requester that did not win the last accepted command.
    assign w_tie_pick1 = ~r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
        end
    end
`else
    assign w_tie_pick1 = 1'b0;
`endif

    assign w_grant1     = req1_valid & (~req0_valid | w_tie_pick1);
    assign w_grant0     = req0_valid & ~w_grant1;
    assign w_can_accept = (r_state == BUF_EMPTY) | rsp_ready;

    assign req0_ready   = w_grant0 & w_can_accept & ~rst;
    assign req1_ready   = w_grant1 & w_can_accept & ~rst;
    assign w_accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_drain      = (r_state == BUF_FULL) & rsp_ready;

    assign w_alu_a  = w_grant1 ? req1_a  : req0_a;
    assign w_alu_b  = w_grant1 ? req1_b  : req0_b;
    assign w_alu_op = w_grant1 ? req1_op : req0_op;

    alu_core #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_alu_core (
        .a      (w_alu_a),
        .b      (w_alu_b),
        .op     (w_alu_op),
        .result (w_alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An accept always refills the buffer, so accept-with-drain has no bubble.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = BUF_FULL;
        end else if (w_drain) begin
            w_state_next = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_ops_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_rsp_data <= w_alu_result;
                r_rsp_id   <= w_grant1;
            end
            if (w_drain) begin
                r_ops_count <= r_ops_count + 8'd1;
            end
        end
    end

    assign rsp_valid = (r_state == BUF_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_count = r_ops_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Self-checking bench for alu_req_arbiter: directed scenarios
//               plus random traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
    logic [7:0] ops_count;

    int total = 0;
    int bad   = 0;

    // Reference model: buffer contents, last winner and handshake count
    bit m_full = 1'b0;
    int m_data = 0;
    bit m_id   = 1'b0;
    bit m_last = 1'b1;
    int m_cnt  = 0;
    bit acc0   = 1'b0;
    bit acc1   = 1'b0;

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .ops_count  (ops_count)
    );

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: readys checked mid-cycle, model advanced and outputs checked after the edge.
    task automatic cyc();
        bit g0, g1, can, e0, e1;
`ifdef ALU_ARB_RR_EN
        g1 = req1_valid && (!req0_valid || !m_last);
`else
        g1 = req1_valid && !req0_valid;
`endif
        g0  = req0_valid && !g1;
        can = !m_full || rsp_ready;
        e0  = !rst && can && g0;
        e1  = !rst && can && g1;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        @(posedge clk);
        #1;
        acc0 = e0 && req0_valid;
        acc1 = e1 && req1_valid;
        if (rst) begin
            m_full = 1'b0; m_data = 0; m_id = 1'b0; m_last = 1'b1; m_cnt = 0;
        end else begin
            if (m_full && rsp_ready) m_cnt = (m_cnt + 1) % 256;
            if (acc0 || acc1) begin
                m_data = acc1 ? alu_ref(int'(req1_a), int'(req1_b), int'(req1_op))
                              : alu_ref(int'(req0_a), int'(req0_b), int'(req0_op));
                m_id   = acc1;
                m_last = acc1;
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("ops_count", 32'(ops_count), 32'(m_cnt));
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] start_cnt;
        bit         exp_id;

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_op = 2'd0;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 2'd0;
        cyc(); cyc();

        // Lone requester 0: 3+5
        rst = 1'b0; req1_valid = 1'b0;
        cyc();
        chk("t1_data", 32'(rsp_data), 32'h08);
        chk("t1_id",   32'(rsp_id),   32'h0);

        // Requester 1 SUB with accept and drain together, then drain alone
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5; req1_op = 2'd1;
        rsp_ready  = 1'b1;
        cyc();
        chk("t2_data", 32'(rsp_data), 32'hFE);
        chk("t2_id",   32'(rsp_id),   32'h1);
        req1_valid = 1'b0;
        cyc();

        // Both requesters valid every cycle
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd7; req0_op = 2'd0;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd4; req1_op = 2'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
`ifdef ALU_ARB_RR_EN
            exp_id = (i % 2) == 1;
`else
            exp_id = 1'b0;
`endif
            chk("t3_grant", 32'(rsp_id), 32'(exp_id));
            chk("t3_valid", 32'(rsp_valid), 32'h1);
        end

        // Backpressure while FULL
        req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 4'hF; req0_b = 4'hA; req0_op = 2'd2;
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_hold", 32'(rsp_data), 32'(held));
        end
        rsp_ready = 1'b1;
        cyc();
        chk("t4_data", 32'(rsp_data), 32'h0A);

        req0_a = 4'hC; req0_b = 4'h3; req0_op = 2'd3;
        cyc();
        chk("t5_or", 32'(rsp_data), 32'h0F);
        req0_a = 4'hF; req0_b = 4'hF; req0_op = 2'd0;
        cyc();
        chk("t5_add", 32'(rsp_data), 32'h1E);

        // 256 back-to-back drains bring the counter back to where it started
        start_cnt = ops_count;
        for (int i = 0; i < 256; i++) cyc();
        chk("t5_wrap", 32'(ops_count), 32'(start_cnt));

        // Random traffic honouring the hold-until-ready rule
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = 4'($urandom_range(0, 15));
                req0_b = 4'($urandom_range(0, 15));
                req0_op = 2'($urandom_range(0, 3));
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = 4'($urandom_range(0, 15));
                req1_b = 4'($urandom_range(0, 15));
                req1_op = 2'($urandom_range(0, 3));
            end
            rsp_ready = 1'($urandom_range(0, 1));
            cyc();
        end

        // Reset while holding a result
        req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'd0;
        cyc();
        chk("t6_full", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1; rst = 1'b1;
        cyc();
        chk("t6_valid", 32'(rsp_valid), 32'h0);
        chk("t6_count", 32'(ops_count), 32'h0);
        rst = 1'b0; req0_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares the single 4-bit ALU datapath between two independent requesters. Each requester presents operands and an opcode over a valid/ready handshake. The block arbitrates between them, drives the shared ALU, and registers the result into a one-entry output buffer that has its own valid/ready handshake. It sits between the pin-level input decoding and the ALU, replacing the direct pin-to-ALU connection.

## Interface
- DATA_W, default 4: operand width.
- RES_W, default 8: result width. Must be ≥ DATA_W+1.
- clk, in, 1: the single clock. All state changes on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- req0_valid, in, 1: requester 0 has a command pending.
- req0_ready, out, 1: requester 0's command is accepted this cycle.
- req0_a, in, DATA_W: requester 0 operand A.
- req0_b, in, DATA_W: requester 0 operand B.
- req0_op, in, 2: requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as the requester 0 ports, for requester 1.
- rsp_valid, out, 1: the output buffer holds a result.
- rsp_ready, in, 1: the consumer takes the result this cycle.
- rsp_id, out, 1: index of the requester that owns the held result.
- rsp_data, out, RES_W: the held result.
- ops_count, out, 8: number of completed response handshakes, modulo 256.

## Operation
- Opcodes:
  - ADD=0: a+b.
  - SUB=1: a−b, modulo 2^RES_W. Example: 3−5 = 0xFE.
  - AND=2: a&b, zero-extended.
  - OR=3: a|b, zero-extended.
  - Operands are zero-extended to RES_W before the operation.
- Output buffer states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL and rsp_ready).
- Arbitration:
  - If exactly one requester has valid=1, it is granted.
  - If both have valid=1, the requester other than last_grant is granted.
  - last_grant is a 1-bit register, reset to 1, so requester 0 wins the first tie.
  - last_grant updates only on an accepted command.
- reqN_ready = grantN & can_accept & !rst. Both readys are combinational, and at most one is high in any cycle.
- Accept (reqN_valid & reqN_ready), on the clock edge:
  - Capture the ALU result of requester N's operands into rsp_data.
  - Set rsp_id=N.
  - Set last_grant=N.
  - Go to or stay in FULL.
- Drain without accept (FULL & rsp_ready, and no accept in the same cycle): go to EMPTY. rsp_data and rsp_id hold their previous values.
- Drain and accept in the same cycle: the new result replaces the old one with no bubble, and the buffer stays FULL.
- ops_count increments on every rsp_valid & rsp_ready and wraps from 255 to 0.
- Requester rules:
  - valid and payload stay stable until ready.
  - The payload is sampled only on the accepting edge.
  - A requester whose valid is low is never granted.
- rsp_data, rsp_id and rsp_valid stay stable while FULL & !rsp_ready.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, ops_count=0, last_grant=1, both readys=0.
- Latency: a command accepted at edge k has rsp_valid=1 after edge k.
- Throughput: one command per cycle while rsp_ready is held high.
- Backpressure: with rsp_ready=0 and FULL, both readys are 0.
- Reset mid-operation: any held result is discarded and no handshake completes in the reset cycle.
- The ALU path is combinational between the requester inputs and the rsp_data register. There is no extra pipeline stage.

## Configuration
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin tie-break through last_grant, as described above.
- Undefined: fixed priority. Requester 0 always wins a tie and the last_grant register is not built. All other behaviour is identical.

## Structure
- Package alu_pkg holds:
  - the opcode localparams ADD, SUB, AND, OR (2-bit);
  - the default DATA_W and RES_W.
- Sub-module alu_core: the purely combinational ALU, with inputs a, b, op and output result of width RES_W, using the arithmetic rules above. It is instantiated once and fed through a 2:1 mux controlled by the grant.
- The top module contains the arbiter, the output buffer and ops_count.

## Test plan
1. Reset → rsp_valid=0, ops_count=0, req0_ready=req1_ready=0 during rst. After release, a lone req0 {a=3, b=5, op=ADD} is accepted; the next cycle shows rsp_data=0x08, rsp_id=0.
2. req1 {3, 5, SUB}, rsp_ready=1 → rsp_data=0xFE, rsp_id=1, ops_count=1 after the drain.
3. Both valid every cycle, rsp_ready=1, ALU_ARB_RR_EN defined → grants alternate 0,1,0,1, with one response per cycle. The same stimulus without the macro → always requester 0.
4. FULL with rsp_ready=0 for 3 cycles, req0 valid {0xF, 0xA, AND} → req0_ready=0 and rsp_data is stable. When rsp_ready rises, the accept and drain happen in the same cycle, then rsp_data=0x0A.
5. {0xC, 0x3, OR} → 0x0F. {0xF, 0xF, ADD} → 0x1E. 256 drained responses → ops_count wraps to 0.
6. rst asserted while FULL → rsp_valid=0 the next cycle, with no drain counted.
